// File: rtl/gpio_uart_tx.sv
// gpio_uart_tx - FIFO-buffered 8N1 serial transmitter.
//
// Bytes presented by the GPIO glue decode (i_data + i_valid) are queued in
// a small circular FIFO and serialised LSB-first onto o_txd as
// start(0) + 8 data bits + stop(1). Every bit lasts CLKS_PER_BIT enabled
// clock cycles. All state advances only on rising i_clk edges where
// i_clk_en is high.
//
// Ports:
//   i_clk    - system clock, rising edge active
//   i_rstb   - asynchronous active-low reset
//   i_clk_en - clock enable; when low all state holds
//   i_data   - byte to transmit
//   i_valid  - i_data valid this cycle
//   o_ready  - FIFO can accept a byte (count != DEPTH)
//   o_txd    - serial line, idles high, driven from a register
//   o_busy   - FIFO non-empty or frame in progress
//   o_count  - FIFO fill level, 0..DEPTH
module gpio_uart_tx #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rstb,
  input  logic                     i_clk_en,
  input  logic [7:0]               i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic                     o_txd,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage (no reset: contents are only meaningful between pointers)
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;

  // Transmitter state
  state_t        state_reg, state_next;
  logic [BW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          txd_reg, txd_next;

  logic          push;
  logic          pop;
  logic          baud_done;
  logic [7:0]    head;

  assign o_ready   = (count_reg != FULL);
  assign push      = i_valid && o_ready;
  assign head      = mem[rd_ptr_reg];
  assign baud_done = (baud_reg == BAUD_LAST);

  assign o_txd   = txd_reg;
  assign o_count = count_reg;
  assign o_busy  = (state_reg != IDLE) || (count_reg != '0);

  // Next-state and datapath decode. The FSM only sees the registered count,
  // so a byte pushed into an empty FIFO is popped one enabled edge later.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    txd_next   = txd_reg;
    pop        = 1'b0;

    case (state_reg)
      IDLE: begin
        txd_next = 1'b1;
        if (count_reg != '0) begin
          pop        = 1'b1;
          shift_next = head;
          state_next = START;
          txd_next   = 1'b0;
          baud_next  = '0;
        end
      end

      START: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = 3'd0;
          state_next = DATA;
          txd_next   = shift_reg[0];
          shift_next = {1'b0, shift_reg[7:1]};
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
            txd_next   = 1'b1;
          end else begin
            bit_next   = bit_reg + 3'd1;
            txd_next   = shift_reg[0];
            shift_next = {1'b0, shift_reg[7:1]};
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end

      STOP: begin
        if (baud_done) begin
          baud_next = '0;
          // Back-to-back frames: go straight to a new start bit if queued.
          if (count_reg != '0) begin
            pop        = 1'b1;
            shift_next = head;
            state_next = START;
            txd_next   = 1'b0;
          end else begin
            state_next = IDLE;
            txd_next   = 1'b1;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        txd_next   = 1'b1;
        baud_next  = '0;
      end
    endcase
  end

  // Simultaneous push and pop leave the fill level unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state_reg  <= IDLE;
      baud_reg   <= '0;
      bit_reg    <= 3'd0;
      shift_reg  <= 8'h00;
      txd_reg    <= 1'b1;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (i_clk_en) begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
      count_reg <= count_next;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clk_en && push) begin
      mem[wr_ptr_reg] <= i_data;
    end
  end

endmodule
